layer_scan_controller: RTL and testbench

//  Sequences LED-cube layer multiplexing; directly upstream of inverting_decoder.

---
 rtl/layer_scan_controller_pkg.sv | 20 ++
 rtl/layer_scan_controller_scan_timer.sv | 39 +++
 rtl/layer_scan_controller.sv | 189 ++++++++++++++++++
 tb/tb_layer_scan_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_scan_controller_pkg.sv
// Shared definitions for the LED-cube layer scan controller: FSM states and default geometry.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package layer_scan_controller_pkg;

    localparam int DEF_NUM_LAYERS   = 16;
    localparam int DEF_ADDR_W       = 4;
    localparam int DEF_DWELL_CYCLES = 1000;
    localparam int DEF_BLANK_CYCLES = 8;
    localparam int DEF_CNT_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRELOAD = 3'd1,
        ST_BLANK   = 3'd2,
        ST_DISPLAY = 3'd3,
        ST_DRAIN   = 3'd4
    } scan_state_t;

endpackage

// File: rtl/layer_scan_controller_scan_timer.sv
// Loadable down-counter: start loads a cycle count, expired is high on the last counted cycle.
// Latency: expired asserts on the Nth cycle after the start edge (N = cycles, N >= 2).
// Backpressure: none; a start always restarts the count, even on the expiring cycle.
// Ports: clk, reset_n (async active-low), start, cycles[CNT_W], count[CNT_W], expired.
module scan_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    logic             active_q;
    logic [CNT_W-1:0] count_q;

    // count holds cycles-1 on the first timed cycle and reaches 0 on the last one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            count_q  <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            count_q  <= cycles - 1'b1;
        end else if (active_q) begin
            if (count_q == '0) begin
                active_q <= 1'b0;
            end else begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign count   = count_q;
    assign expired = active_q && (count_q == '0);

endmodule

// File: rtl/layer_scan_controller.sv
// LED-cube layer multiplexer: preloads layer N+1 through the column loader while layer N is lit,
// latency: layer period DWELL_CYCLES+BLANK_CYCLES; latch/addr update on cycle 2 of each blank window.
// Backpressure: a late load_done stretches the lit layer (sticky underrun) instead of switching early.
// Ports: clk, reset_n | enable, load_done in | load_req, load_layer, latch, blank, addr,
//        frame_start, underrun out (all registered).
module layer_scan_controller
    import layer_scan_controller_pkg::*;
#(
    parameter int NUM_LAYERS   = DEF_NUM_LAYERS,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              load_done,
    output logic              load_req,
    output logic [ADDR_W-1:0] load_layer,
    output logic              latch,
    output logic              blank,
    output logic [ADDR_W-1:0] addr,
    output logic              frame_start,
    output logic              underrun
);

    localparam logic [CNT_W-1:0]  DWELL_LEN   = CNT_W'(DWELL_CYCLES);
    localparam logic [CNT_W-1:0]  BLANK_LEN   = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0]  BLANK_FIRST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_LAYER  = ADDR_W'(NUM_LAYERS - 1);

    scan_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] load_layer_q, load_layer_d;
    logic              load_req_q, load_req_d;
    logic              latch_q, latch_d;
    logic              frame_start_q, frame_start_d;
    logic              blank_q, blank_d;
    logic              underrun_q, underrun_d;
    // Set when the dwell ran out while the next layer was still loading.
    logic              stall_q, stall_d;

    logic              tmr_start;
    logic [CNT_W-1:0]  tmr_cycles;
    logic [CNT_W-1:0]  tmr_count;
    logic              tmr_expired;
    logic              load_ok;

    // One timer serves both windows; blank and dwell never overlap.
    scan_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (tmr_start),
        .cycles  (tmr_cycles),
        .count   (tmr_count),
        .expired (tmr_expired)
    );

    // A load_done only counts while a request is outstanding.
    assign load_ok = load_req_q && load_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            load_layer_q  <= '0;
            load_req_q    <= 1'b0;
            latch_q       <= 1'b0;
            frame_start_q <= 1'b0;
            blank_q       <= 1'b1;
            underrun_q    <= 1'b0;
            stall_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            load_layer_q  <= load_layer_d;
            load_req_q    <= load_req_d;
            latch_q       <= latch_d;
            frame_start_q <= frame_start_d;
            blank_q       <= blank_d;
            underrun_q    <= underrun_d;
            stall_q       <= stall_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        load_layer_d  = load_layer_q;
        load_req_d    = load_req_q;
        latch_d       = 1'b0;
        frame_start_d = 1'b0;
        blank_d       = blank_q;
        underrun_d    = underrun_q;
        stall_d       = stall_q;
        tmr_start     = 1'b0;
        tmr_cycles    = DWELL_LEN;

        // Request drops the cycle after the loader's answer is sampled.
        if (load_ok) begin
            load_req_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                blank_d = 1'b1;
                if (enable) begin
                    load_layer_d = '0;
                    load_req_d   = 1'b1;
                    state_d      = ST_PRELOAD;
                end
            end

            ST_PRELOAD: begin
                if (load_ok) begin
                    tmr_start  = 1'b1;
                    tmr_cycles = BLANK_LEN;
                    state_d    = ST_BLANK;
                end
            end

            ST_BLANK: begin
                // Registered, so latch/addr/frame_start appear on the second blank cycle.
                if (tmr_count == BLANK_FIRST) begin
                    latch_d       = 1'b1;
                    addr_d        = load_layer_q;
                    frame_start_d = (load_layer_q == '0);
                end
                if (tmr_expired) begin
                    blank_d      = 1'b0;
                    load_layer_d = (addr_q == LAST_LAYER) ? '0 : addr_q + 1'b1;
                    load_req_d   = 1'b1;
                    tmr_start    = 1'b1;
                    tmr_cycles   = DWELL_LEN;
                    stall_d      = 1'b0;
                    state_d      = ST_DISPLAY;
                end
            end

            ST_DISPLAY: begin
                if (stall_q) begin
                    // Keep the current layer lit until the late load arrives.
                    if (load_ok) begin
                        blank_d    = 1'b1;
                        tmr_start  = 1'b1;
                        tmr_cycles = BLANK_LEN;
                        stall_d    = 1'b0;
                        state_d    = ST_BLANK;
                    end
                end else if (tmr_expired) begin
                    if (!enable) begin
                        blank_d = 1'b1;
                        state_d = ST_DRAIN;
                    end else if (!load_req_q || load_ok) begin
                        blank_d    = 1'b1;
                        tmr_start  = 1'b1;
                        tmr_cycles = BLANK_LEN;
                        state_d    = ST_BLANK;
                    end else begin
                        underrun_d = 1'b1;
                        stall_d    = 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                blank_d = 1'b1;
                if (!load_req_q || load_ok) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                blank_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign load_req    = load_req_q;
    assign load_layer  = load_layer_q;
    assign latch       = latch_q;
    assign blank       = blank_q;
    assign addr        = addr_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_layer_scan_controller.sv
// Bench for layer_scan_controller with a behavioural column loader and a latch scoreboard.
// Latency: layer period 24 cycles (DWELL 20 + BLANK 4), loader answers 3 cycles after a request.
// Backpressure: the loader can be told to answer one chosen layer 30 cycles late.
module tb_layer_scan_controller;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       load_done;
    logic       load_req;
    logic [3:0] load_layer;
    logic       latch;
    logic       blank;
    logic [3:0] addr;
    logic       frame_start;
    logic       underrun;

    layer_scan_controller #(
        .NUM_LAYERS   (16),
        .ADDR_W       (4),
        .DWELL_CYCLES (20),
        .BLANK_CYCLES (4),
        .CNT_W        (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .load_done   (load_done),
        .load_req    (load_req),
        .load_layer  (load_layer),
        .latch       (latch),
        .blank       (blank),
        .addr        (addr),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: layer numbers the loader has delivered, in the order they must be latched.
    int exp_q[$];
    int exp_layer;
    int n_latch;
    int n_fs;
    int last_exp_addr;
    int cyc;
    int last_lc;

    // Controls written only by the main sequence.
    bit chk_period;
    int long_layer;
    int stray_tgt;
    int restart_tgt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Loader model and latch monitor share one process so the scoreboard has a single writer.
    initial begin : agent
        int  cnt;
        bit  pending;
        int  stray_done;
        int  restart_done;
        int  lay;
        cnt = 0; pending = 0; stray_done = 0; restart_done = 0; lay = 0;
        exp_layer = 0; n_latch = 0; n_fs = 0; last_exp_addr = 0; cyc = 0; last_lc = -1;
        load_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            load_done = 1'b0;

            if (latch) begin
                n_latch++;
                check("latch_blank", blank, 1);
                check("latch_q_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    lay = exp_q.pop_front();
                    check("latch_addr", addr, lay);
                    check("latch_frame_start", frame_start, lay == 0);
                    if (lay == 0) n_fs++;
                    last_exp_addr = lay;
                end
                if (chk_period && last_lc >= 0) check("latch_period", cyc - last_lc, 24);
                last_lc = cyc;
            end else begin
                check("frame_start_no_latch", frame_start, 0);
            end

            if (restart_done != restart_tgt) begin
                exp_layer    = 0;
                exp_q.delete();
                restart_done = restart_tgt;
            end

            if (!reset_n) begin
                pending   = 0;
                exp_layer = 0;
                exp_q.delete();
            end else if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    load_done = 1'b1;
                    exp_q.push_back(exp_layer);
                    exp_layer = (exp_layer + 1) % 16;
                    pending   = 0;
                end
            end else if (load_req) begin
                check("load_layer", load_layer, exp_layer);
                pending = 1;
                cnt     = (exp_layer == long_layer) ? 30 : 3;
            end else if (stray_done != stray_tgt) begin
                load_done  = 1'b1;
                stray_done = stray_tgt;
            end
        end
    end

    initial begin : main_seq
        int n;
        int base;
        reset_n = 1'b0; enable = 1'b0;
        chk_period = 0; long_layer = -1; stray_tgt = 0; restart_tgt = 0;

        // 1: reset values, then idle with enable low
        repeat (2) tick();
        check("rst_blank", blank, 1);
        check("rst_addr", addr, 0);
        check("rst_load_req", load_req, 0);
        check("rst_load_layer", load_layer, 0);
        check("rst_latch", latch, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_underrun", underrun, 0);
        reset_n = 1'b1;
        repeat (50) tick();
        check("t1_blank", blank, 1);
        check("t1_addr", addr, 0);
        check("t1_load_req", load_req, 0);
        check("t1_no_latch", n_latch, 0);

        // 2: full scan 0..15,0 at 24-cycle period
        chk_period = 1;
        enable = 1'b1;
        n = 0;
        while (n_latch < 17 && n < 700) begin tick(); n++; end
        check("t2_latch_count", n_latch, 17);
        check("t2_frame_starts", n_fs, 2);
        check("t2_underrun", underrun, 0);
        chk_period = 0;

        // 3: layer 1 answered late -> underrun, layer stays lit, then resumes
        long_layer = 1;
        n = 0;
        while (!underrun && n < 60) begin tick(); n++; end
        check("t3_underrun", underrun, 1);
        check("t3_blank_stall", blank, 0);
        check("t3_req_pending", load_req, 1);
        while (!load_done && n < 100) begin tick(); n++; end
        check("t3_done_seen", load_done, 1);
        check("t3_blank_at_done", blank, 0);
        tick();
        check("t3_blank_after_done", blank, 1);
        check("t3_req_drop", load_req, 0);
        tick();
        check("t3_latch_resume", latch, 1);
        long_layer = 6;

        // 4: stray load_done while no request is outstanding
        repeat (10) tick();
        base = n_latch;
        stray_tgt++;
        repeat (3) tick();
        check("t4_addr", addr, last_exp_addr);
        check("t4_blank", blank, 0);
        check("t4_load_req", load_req, 0);
        check("t4_no_latch", n_latch, base);

        // 5: disable while layer 6 load is pending at addr 5
        n = 0;
        while (!(latch && addr == 4'd5) && n < 400) begin tick(); n++; end
        check("t5_latch5", latch, 1);
        repeat (5) tick();
        enable = 1'b0;
        base = n_latch;
        n = 0;
        while (!blank && n < 60) begin tick(); n++; end
        check("t5_dwell_len", n, 18);
        check("t5_drain_blank", blank, 1);
        check("t5_req_held", load_req, 1);
        check("t5_addr_drain", addr, 5);
        n = 0;
        while (!load_done && n < 60) begin tick(); n++; end
        check("t5_done_seen", load_done, 1);
        tick();
        check("t5_req_drop", load_req, 0);
        repeat (5) tick();
        check("t5_idle_blank", blank, 1);
        check("t5_idle_addr", addr, 5);
        check("t5_idle_req", load_req, 0);
        check("t5_no_latch", n_latch, base);

        // 6: restart, then reset in the middle of a blank window
        long_layer = -1;
        restart_tgt++;
        enable = 1'b1;
        base = n_latch;
        n = 0;
        while (n_latch < base + 2 && n < 200) begin tick(); n++; end
        check("t6_two_latches", n_latch, base + 2);
        reset_n = 1'b0;
        #1;
        check("t6_rst_blank", blank, 1);
        check("t6_rst_load_req", load_req, 0);
        check("t6_rst_latch", latch, 0);
        check("t6_rst_addr", addr, 0);
        check("t6_rst_underrun", underrun, 0);
        repeat (3) tick();
        reset_n = 1'b1;
        n = 0;
        while (!load_req && n < 20) begin tick(); n++; end
        check("t6_preload_req", load_req, 1);
        check("t6_preload_layer", load_layer, 0);
        base = n_latch;
        n = 0;
        while (n_latch == base && n < 40) begin tick(); n++; end
        check("t6_relatch", n_latch, base + 1);
        check("t6_relatch_addr", addr, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
